// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator: FSM state encoding and the
// width-clamp helpers used when a new frame latches its pulse width.
package pulse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int DEFAULT_PERIOD = 20000;

   // Largest width a frame may carry: one tick is always reserved for the low phase.
   function automatic logic [31:0] width_limit(input int period);
      return 32'(period - 1);
   endfunction

   function automatic logic [31:0] clamp_width(input logic [31:0] w, input logic [31:0] limit);
      return (w > limit) ? limit : w;
   endfunction

endpackage

// File: rtl/tick_div.sv
// Restartable divide-by-PREDIV tick generator; tick_o is high for one clk
// every PREDIV cycles while run_i is asserted.
module tick_div #(
   parameter int PREDIV = 50
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int DW = (PREDIV > 1) ? $clog2(PREDIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(PREDIV - 1);

   logic [DW-1:0] div_q, div_d;

   always_comb begin
      div_d = div_q;
      if (restart_i || !run_i || (div_q == LAST)) begin
         div_d = '0;
      end else begin
         div_d = div_q + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign tick_o = run_i && (div_q == LAST);

endmodule

// File: rtl/pulse_gen.sv
// Frame-based pulse generator: each frame is PERIOD ticks long and starts with
// a pulse of active_width ticks; new widths are shadowed until the next frame.
module pulse_gen
   import pulse_pkg::*;
#(
   parameter  int PREDIV = 50,
   parameter  int PERIOD = DEFAULT_PERIOD,
   parameter  int MAXV   = 4096,
   localparam int W      = $clog2(MAXV)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   input  logic [W-1:0] width_in,
   input  logic         width_stb,
   output logic         pulse_out,
   output logic         frame_stb,
   output logic [W-1:0] active_width,
   output logic         pending
);

   localparam int TW = $clog2(PERIOD);
   localparam logic [31:0] WIDTH_LIMIT = width_limit(PERIOD);

   state_t        state_q, state_d;
   logic [W-1:0]  shadow_q, shadow_d;
   logic [W-1:0]  active_q, active_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          pending_q, pending_d;
   logic          pulse_q, pulse_d;
   logic          stb_q, stb_d;
   logic          armed_q;
   logic          tick;
   logic          frame_start;
   logic [W-1:0]  start_width;

   tick_div #(
      .PREDIV(PREDIV)
   ) u_tick_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .run_i    (state_q != IDLE),
      .restart_i(frame_start),
      .tick_o   (tick)
   );

   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      tick_d      = tick_q;
      pending_d   = pending_q;
      pulse_d     = pulse_q;
      stb_d       = 1'b0;
      frame_start = 1'b0;
      // A strobe landing on the frame-start edge takes effect immediately.
      start_width = W'(clamp_width(32'(width_stb ? width_in : shadow_q), WIDTH_LIMIT));

      case (state_q)
         IDLE: begin
            tick_d      = '0;
            pulse_d     = 1'b0;
            frame_start = enable && armed_q;
         end
         HIGH: begin
            if (tick) begin
               tick_d = tick_q + TW'(1);
               if ((32'(tick_q) + 32'd1) == 32'(active_q)) begin
                  state_d = LOW;
                  pulse_d = 1'b0;
               end
            end
         end
         LOW: begin
            if (tick) begin
               if (tick_q == TW'(PERIOD - 1)) begin
                  tick_d = '0;
                  if (enable) begin
                     frame_start = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            pulse_d = 1'b0;
         end
      endcase

      if (width_stb) begin
         shadow_d  = width_in;
         pending_d = 1'b1;
      end

      if (frame_start) begin
         active_d  = start_width;
         pending_d = 1'b0;
         tick_d    = '0;
         stb_d     = 1'b1;
         pulse_d   = (start_width != '0);
         state_d   = (start_width != '0) ? HIGH : LOW;
      end
   end

   // armed_q holds off the first frame until one clean edge after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         active_q  <= '0;
         tick_q    <= '0;
         pending_q <= 1'b0;
         pulse_q   <= 1'b0;
         stb_q     <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         tick_q    <= tick_d;
         pending_q <= pending_d;
         pulse_q   <= pulse_d;
         stb_q     <= stb_d;
         armed_q   <= 1'b1;
      end
   end

   assign pulse_out    = pulse_q;
   assign frame_stb    = stb_q;
   assign active_width = active_q;
   assign pending      = pending_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen with PREDIV=2, PERIOD=10, MAXV=16: a width table
// plus hand sequences for shadow loading, enable drop and asynchronous reset.
module tb_pulse_gen;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic [3:0] width_in;
   logic       width_stb;
   logic       pulse_out;
   logic       frame_stb;
   logic [3:0] active_width;
   logic       pending;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] width;
      int         aw;
      int         hi;
      int         len;
   } vec_t;

   vec_t vecs[7];

   pulse_gen #(
      .PREDIV(2),
      .PERIOD(10),
      .MAXV  (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .width_in    (width_in),
      .width_stb   (width_stb),
      .pulse_out   (pulse_out),
      .frame_stb   (frame_stb),
      .active_width(active_width),
      .pending     (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_stb(input string name);
      int n = 0;
      while (!frame_stb && n < 100) begin
         step();
         n++;
      end
      check(name, int'(frame_stb), 1);
   endtask

   // Starts on the first cycle of a frame; ends on the first cycle of the next.
   task automatic measure_frame(output int hi, output int len);
      hi  = 0;
      len = 0;
      do begin
         if (pulse_out) hi++;
         len++;
         step();
      end while (!frame_stb && len < 200);
   endtask

   initial begin
      int hi, len, pc, bad, stbs, prev_aw;

      vecs[0] = '{width: 4'd1,  aw: 1, hi: 2,  len: 20};
      vecs[1] = '{width: 4'd12, aw: 9, hi: 18, len: 20};
      vecs[2] = '{width: 4'd9,  aw: 9, hi: 18, len: 20};
      vecs[3] = '{width: 4'd15, aw: 9, hi: 18, len: 20};
      vecs[4] = '{width: 4'd0,  aw: 0, hi: 0,  len: 20};
      vecs[5] = '{width: 4'd4,  aw: 4, hi: 8,  len: 20};
      vecs[6] = '{width: 4'd3,  aw: 3, hi: 6,  len: 20};

      reset_n   = 1'b0;
      enable    = 1'b0;
      width_in  = '0;
      width_stb = 1'b0;
      repeat (3) step();
      check("rst_pulse", int'(pulse_out), 0);
      check("rst_stb", int'(frame_stb), 0);
      check("rst_aw", int'(active_width), 0);
      check("rst_pending", int'(pending), 0);

      // First frame may start on the second edge after reset release, not the first.
      reset_n = 1'b1;
      enable  = 1'b1;
      step();
      check("first_edge_no_stb", int'(frame_stb), 0);
      step();
      check("second_edge_stb", int'(frame_stb), 1);
      check("w0_aw", int'(active_width), 0);
      measure_frame(hi, len);
      check("w0_hi", hi, 0);
      check("w0_len", len, 20);
      prev_aw = 0;

      foreach (vecs[i]) begin
         step();
         step();
         width_in  = vecs[i].width;
         width_stb = 1'b1;
         step();
         width_stb = 1'b0;
         check($sformatf("v%0d_pending_set", i), int'(pending), 1);
         check($sformatf("v%0d_aw_held", i), int'(active_width), prev_aw);
         wait_stb($sformatf("v%0d_stb", i));
         check($sformatf("v%0d_aw", i), int'(active_width), vecs[i].aw);
         check($sformatf("v%0d_pending_clr", i), int'(pending), 0);
         measure_frame(hi, len);
         check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("v%0d_len", i), len, vecs[i].len);
         prev_aw = vecs[i].aw;
      end

      // Width 5 loaded during a width-3 frame waits for the next frame.
      hi  = 0;
      pc  = 0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (pulse_out) hi++;
         if (pending) pc++;
         if (active_width != 4'd3) bad++;
         if (c == 2) begin
            width_in  = 4'd5;
            width_stb = 1'b1;
         end else begin
            width_stb = 1'b0;
         end
         step();
      end
      check("shadow_cur_hi", hi, 6);
      check("shadow_pending_cycles", pc, 17);
      check("shadow_aw_held", bad, 0);
      check("shadow_next_stb", int'(frame_stb), 1);
      check("shadow_next_pending", int'(pending), 0);
      check("shadow_next_aw", int'(active_width), 5);
      measure_frame(hi, len);
      check("shadow_next_hi", hi, 10);
      check("shadow_next_len", len, 20);

      // Strobe on the frame-start edge applies directly and leaves pending low.
      repeat (19) step();
      width_in  = 4'd7;
      width_stb = 1'b1;
      step();
      width_stb = 1'b0;
      check("coinc_stb", int'(frame_stb), 1);
      check("coinc_aw", int'(active_width), 7);
      check("coinc_pending", int'(pending), 0);
      measure_frame(hi, len);
      check("coinc_hi", hi, 14);
      check("coinc_len", len, 20);
      check("coinc_aw_next", int'(active_width), 7);

      // Enable dropped on the second pulse cycle: frame completes, then idle.
      step();
      step();
      width_in  = 4'd3;
      width_stb = 1'b1;
      step();
      width_stb = 1'b0;
      wait_stb("drop_stb");
      hi   = 0;
      stbs = 0;
      for (int c = 0; c < 60; c++) begin
         if (pulse_out) hi++;
         if (c >= 1 && frame_stb) stbs++;
         if (c == 1) enable = 1'b0;
         step();
      end
      check("drop_hi", hi, 6);
      check("drop_no_stb", stbs, 0);

      width_in  = 4'd2;
      width_stb = 1'b1;
      step();
      width_stb = 1'b0;
      check("idle_pending", int'(pending), 1);
      check("idle_pulse", int'(pulse_out), 0);
      check("idle_stb", int'(frame_stb), 0);
      enable = 1'b1;
      step();
      check("reen_stb", int'(frame_stb), 1);
      check("reen_aw", int'(active_width), 2);
      check("reen_pending", int'(pending), 0);
      check("reen_pulse", int'(pulse_out), 1);

      // Asynchronous reset in the middle of a pulse with a pending width.
      width_in  = 4'd4;
      width_stb = 1'b1;
      step();
      width_stb = 1'b0;
      check("pre_rst_pending", int'(pending), 1);
      check("pre_rst_pulse", int'(pulse_out), 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_pulse", int'(pulse_out), 0);
      check("async_stb", int'(frame_stb), 0);
      check("async_aw", int'(active_width), 0);
      check("async_pending", int'(pending), 0);
      bad = 0;
      repeat (3) begin
         step();
         if (pulse_out || frame_stb || active_width != 0 || pending) bad++;
      end
      enable  = 1'b0;
      reset_n = 1'b1;
      repeat (5) begin
         step();
         if (pulse_out || frame_stb || active_width != 0 || pending) bad++;
      end
      check("rst_hold_zero", bad, 0);
      enable = 1'b1;
      step();
      check("post_rst_stb", int'(frame_stb), 1);
      check("post_rst_aw", int'(active_width), 0);
      measure_frame(hi, len);
      check("post_rst_hi", hi, 0);
      check("post_rst_len", len, 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
